// File: rtl/prbs_pkg.sv
// Shared types for the pattern-then-PRBS generator: FSM states,
// mode encodings and per-mode LFSR tap/width constants.
package prbs_pkg;

    localparam int LFSR_W = 31;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_REPLAY = 2'd1,
        ST_PRBS   = 2'd2
    } state_e;

    localparam logic [1:0] MODE_PRBS7  = 2'd0;
    localparam logic [1:0] MODE_PRBS9  = 2'd1;
    localparam logic [1:0] MODE_PRBS15 = 2'd2;
    localparam logic [1:0] MODE_PRBS31 = 2'd3;

    function automatic logic [4:0] tap_a(input logic [1:0] m);
        case (m)
            MODE_PRBS9:  tap_a = 5'd8;
            MODE_PRBS15: tap_a = 5'd14;
            MODE_PRBS31: tap_a = 5'd30;
            default:     tap_a = 5'd6;
        endcase
    endfunction

    function automatic logic [4:0] tap_b(input logic [1:0] m);
        case (m)
            MODE_PRBS9:  tap_b = 5'd4;
            MODE_PRBS15: tap_b = 5'd13;
            MODE_PRBS31: tap_b = 5'd27;
            default:     tap_b = 5'd5;
        endcase
    endfunction

    function automatic logic [LFSR_W-1:0] width_mask(input logic [1:0] m);
        case (m)
            MODE_PRBS9:  width_mask = 31'h0000_01FF;
            MODE_PRBS15: width_mask = 31'h0000_7FFF;
            MODE_PRBS31: width_mask = 31'h7FFF_FFFF;
            default:     width_mask = 31'h0000_007F;
        endcase
    endfunction

endpackage

// File: rtl/prbs_pattern_gen_if.sv
// Load and output valid/ready streams of the pattern generator.
// master: the generator side; slave: the environment side.
interface prbs_pattern_gen_if #(parameter int DATA_W = 8);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

endinterface

// File: rtl/prbs_lfsr_step.sv
// Combinational multi-step Fibonacci LFSR: advances the 31-bit state
// DATA_W times for the selected mode and returns the emitted word.
module prbs_lfsr_step
    import prbs_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [LFSR_W-1:0] state_in,
    input  logic [1:0]        mode,
    output logic [LFSR_W-1:0] state_out,
    output logic [DATA_W-1:0] word
);

    logic [4:0]        a;
    logic [4:0]        b;
    logic [LFSR_W-1:0] m;
    logic [LFSR_W-1:0] s;
    logic              nb;

    always_comb begin
        a    = tap_a(mode);
        b    = tap_b(mode);
        m    = width_mask(mode);
        s    = state_in & m;
        nb   = 1'b0;
        word = '0;
        // first generated bit lands in the MSB
        for (int i = 0; i < DATA_W; i++) begin
            nb = s[a] ^ s[b];
            s  = {s[LFSR_W-2:0], nb} & m;
            word[DATA_W-1-i] = nb;
        end
        state_out = s;
    end

endmodule

// File: rtl/prbs_pattern_gen.sv
// Pattern-then-PRBS word generator; optional err_inject port is
// enabled by defining PRBS_ERR_INJECT_EN.
module prbs_pattern_gen
    import prbs_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                clear,
    prbs_pattern_gen_if.master  bus,
    input  logic [CNT_W-1:0]    n_pattern,
    input  logic [1:0]          mode,
`ifdef PRBS_ERR_INJECT_EN
    input  logic                err_inject,
`endif
    output logic                replay_done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pat_q [DEPTH];
    logic [IDX_W-1:0]  wr_q, wr_d;
    logic [IDX_W-1:0]  rd_q, rd_d, rd_inc;
    logic [CNT_W-1:0]  rep_q, rep_d;
    logic [CNT_W-1:0]  npat_q, npat_d;
    logic [1:0]        mode_q, mode_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              pat_we;
    logic              inj;

    logic [LFSR_W-1:0] step_in, step_out;
    logic [1:0]        step_mode;
    logic [DATA_W-1:0] step_word;

    // in LOAD the step runs from the fresh seed so a direct jump to PRBS
    // can present its first word on the next cycle
    assign step_in   = (state_q == ST_LOAD) ? width_mask(mode) : lfsr_q;
    assign step_mode = (state_q == ST_LOAD) ? mode : mode_q;
    assign rd_inc    = rd_q + IDX_W'(1);

    prbs_lfsr_step #(.DATA_W(DATA_W)) u_step (
        .state_in  (step_in),
        .mode      (step_mode),
        .state_out (step_out),
        .word      (step_word)
    );

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        rep_d   = rep_q;
        npat_d  = npat_q;
        mode_d  = mode_q;
        lfsr_d  = lfsr_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        pat_we  = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                if (bus.in_valid) begin
                    pat_we = 1'b1;
                    wr_d   = wr_q + IDX_W'(1);
                    if (wr_q == LAST) begin
                        wr_d    = '0;
                        npat_d  = n_pattern;
                        mode_d  = mode;
                        valid_d = 1'b1;
                        if (n_pattern != '0) begin
                            state_d = ST_REPLAY;
                            lfsr_d  = width_mask(mode);
                            data_d  = (LAST == '0) ? bus.in_data : pat_q[0];
                        end else begin
                            state_d = ST_PRBS;
                            lfsr_d  = step_out;
                            data_d  = step_word;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            ST_REPLAY: begin
                if (bus.out_ready) begin
                    if (rd_q == LAST) begin
                        rd_d   = '0;
                        rep_d  = rep_q + CNT_W'(1);
                        data_d = pat_q[0];
                        if (rep_q == npat_q - CNT_W'(1)) begin
                            state_d = ST_PRBS;
                            lfsr_d  = step_out;
                            data_d  = step_word;
                            done_d  = 1'b1;
                        end
                    end else begin
                        rd_d   = rd_inc;
                        data_d = pat_q[rd_inc];
                    end
                end
            end
            ST_PRBS: begin
                if (bus.out_ready) begin
                    lfsr_d = step_out;
                    data_d = step_word;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || clear) state_q <= ST_LOAD;
        else              state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            wr_q    <= '0;
            rd_q    <= '0;
            rep_q   <= '0;
            npat_q  <= '0;
            mode_q  <= '0;
            lfsr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            rep_q   <= rep_d;
            npat_q  <= npat_d;
            mode_q  <= mode_d;
            lfsr_q  <= lfsr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // a soft clear keeps the captured pattern
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) pat_q[i] <= '0;
        end else if (!clear && pat_we) begin
            pat_q[wr_q] <= bus.in_data;
        end
    end

`ifdef PRBS_ERR_INJECT_EN
    assign inj = err_inject & (state_q == ST_PRBS);
`else
    assign inj = 1'b0;
`endif

    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q ^ DATA_W'(inj);
    assign replay_done   = done_q;

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// Randomized self-checking bench for prbs_pattern_gen against a
// bit-history PRBS recurrence model.
module tb_prbs_pattern_gen;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;

    typedef logic [DATA_W-1:0] wq_t[$];

    logic             CLK;
    logic             RST;
    logic             clear;
    logic [CNT_W-1:0] n_pattern;
    logic [1:0]       mode;
    logic             replay_done;
`ifdef PRBS_ERR_INJECT_EN
    logic             err_inject;
`endif

    prbs_pattern_gen_if #(.DATA_W(DATA_W)) bus ();

    prbs_pattern_gen #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .clear       (clear),
        .bus         (bus.master),
        .n_pattern   (n_pattern),
        .mode        (mode),
`ifdef PRBS_ERR_INJECT_EN
        .err_inject  (err_inject),
`endif
        .replay_done (replay_done)
    );

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] pat [DEPTH];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: expected words = pattern x n, then PRBS bits from the
    // recurrence bit[k] = bit[k-1-A] ^ bit[k-1-B] with W leading ones.
    task automatic build_exp(input int n, input logic [1:0] md, input int count,
                             output wq_t e);
        int wd, t1, t2;
        bit h[$];
        bit nb;
        logic [DATA_W-1:0] wv;
        e = {};
        for (int r = 0; r < n; r++)
            for (int i = 0; i < DEPTH; i++)
                if (e.size() < count) e.push_back(pat[i]);
        case (md)
            2'd0:    begin wd = 7;  t1 = 6;  t2 = 5;  end
            2'd1:    begin wd = 9;  t1 = 8;  t2 = 4;  end
            2'd2:    begin wd = 15; t1 = 14; t2 = 13; end
            default: begin wd = 31; t1 = 30; t2 = 27; end
        endcase
        for (int i = 0; i < wd; i++) h.push_back(1'b1);
        while (e.size() < count) begin
            wv = '0;
            for (int j = 0; j < DATA_W; j++) begin
                nb = h[h.size()-1-t1] ^ h[h.size()-1-t2];
                h.push_back(nb);
                wv = {wv[DATA_W-2:0], nb};
            end
            while (h.size() > 64) void'(h.pop_front());
            e.push_back(wv);
        end
    endtask

    task automatic load(input logic [CNT_W-1:0] n, input logic [1:0] md);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = DATA_W'($urandom);
                @(negedge CLK);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = pat[i];
            n_pattern    = (i == DEPTH - 1) ? n : CNT_W'($urandom);
            mode         = (i == DEPTH - 1) ? md : 2'($urandom);
        end
        @(negedge CLK);
        bus.in_valid = 1'b0;
        bus.in_data  = DATA_W'($urandom);
        n_pattern    = CNT_W'($urandom);
        mode         = 2'($urandom);
    endtask

    task automatic collect(input int count, input int rmode, input int inj_idx,
                           output wq_t w, output int done_idx, output int done_cnt,
                           output int stall_err, output int timeout);
        logic [DATA_W-1:0] pdata;
        bit pst;
        int cyc;
        w = {};
        done_idx = -1;
        done_cnt = 0;
        stall_err = 0;
        timeout = 0;
        pst = 0;
        pdata = '0;
        cyc = 0;
        while (w.size() < count) begin
            if (cyc > count * 20 + 50) begin
                timeout = 1;
                break;
            end
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 2 == 0);
                default: bus.out_ready = 1'($urandom);
            endcase
`ifdef PRBS_ERR_INJECT_EN
            err_inject = (w.size() == inj_idx);
`else
            if (inj_idx >= 0) timeout = timeout;
`endif
            #1;
            if (replay_done === 1'b1) begin
                done_cnt++;
                if (done_idx < 0) done_idx = w.size();
            end
            if (pst && bus.out_data !== pdata) stall_err++;
            pst   = (bus.out_valid === 1'b1) && !bus.out_ready;
            pdata = bus.out_data;
            if (bus.out_valid === 1'b1 && bus.out_ready) w.push_back(bus.out_data);
            cyc++;
            @(negedge CLK);
        end
        bus.out_ready = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
        err_inject = 1'b0;
`endif
    endtask

    task automatic soft_restart();
        @(negedge CLK);
        clear = 1'b1;
        @(negedge CLK);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== '0) begin
            errors++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        checks++;
        if (replay_done !== 1'b0) begin
            errors++; $display("FAIL reset_replay_done got=%b exp=0", replay_done);
        end
        RST = 1'b0;
    endtask

    task automatic test_basic();
        wq_t w, e;
        int di, dc, se, to;
        pat[0] = 8'h10; pat[1] = 8'hAB; pat[2] = 8'hCD; pat[3] = 8'hEF;
        load(1, 2'd0);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL basic_latency got=%b exp=1", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL basic_in_ready got=%b exp=0", bus.in_ready);
        end
        collect(6, 0, -1, w, di, dc, se, to);
        build_exp(1, 2'd0, 6, e);
        checks++;
        if (to != 0) begin
            errors++; $display("FAIL basic_timeout got=%0d words exp=6", w.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (w[i] !== e[i]) begin
                errors++; $display("FAIL basic_word%0d got=%h exp=%h", i, w[i], e[i]);
            end
        end
        checks++;
        if (w[4] !== 8'h02 || w[5] !== 8'h0C) begin
            errors++; $display("FAIL basic_prbs_head got=%h,%h exp=02,0c", w[4], w[5]);
        end
        checks++;
        if (dc != 1 || di != 4) begin
            errors++; $display("FAIL basic_replay_done got=cnt%0d@%0d exp=cnt1@4", dc, di);
        end
    endtask

    task automatic test_backpressure();
        wq_t w, e;
        int di, dc, se, to;
        soft_restart();
        pat[0] = 8'h10; pat[1] = 8'hAB; pat[2] = 8'hCD; pat[3] = 8'hEF;
        load(2, 2'd0);
        collect(9, 1, -1, w, di, dc, se, to);
        build_exp(2, 2'd0, 9, e);
        checks++;
        if (to != 0) begin
            errors++; $display("FAIL bp_timeout got=%0d words exp=9", w.size());
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (w[i] !== e[i]) begin
                errors++; $display("FAIL bp_word%0d got=%h exp=%h", i, w[i], e[i]);
            end
        end
        checks++;
        if (se != 0) begin
            errors++; $display("FAIL bp_stall_hold got=%0d changes exp=0", se);
        end
        checks++;
        if (w[8] !== 8'h02 || di != 8) begin
            errors++; $display("FAIL bp_prbs_entry got=%h@%0d exp=02@8", w[8], di);
        end
    endtask

    task automatic test_period();
        wq_t w, e;
        int di, dc, se, to, bad;
        soft_restart();
        for (int i = 0; i < DEPTH; i++) pat[i] = DATA_W'($urandom);
        load(0, 2'd0);
        collect(128, 2, -1, w, di, dc, se, to);
        build_exp(0, 2'd0, 128, e);
        bad = 0;
        for (int i = 0; i < 128; i++) if (w[i] !== e[i]) bad++;
        checks++;
        if (to != 0 || bad != 0) begin
            errors++; $display("FAIL period_stream got=%0d bad of %0d exp=0 bad of 128", bad, w.size());
        end
        checks++;
        if (w[0] !== 8'h02 || w[127] !== 8'h02) begin
            errors++; $display("FAIL period_wrap got=%h..%h exp=02..02", w[0], w[127]);
        end
        checks++;
        if (di != 0 || se != 0) begin
            errors++; $display("FAIL period_done_stall got=done@%0d stall%0d exp=done@0 stall0", di, se);
        end
    endtask

    task automatic test_random();
        wq_t w, e;
        int di, dc, se, to, n, cnt, bad;
        logic [1:0] md;
        for (int it = 0; it < 8; it++) begin
            soft_restart();
            for (int i = 0; i < DEPTH; i++) pat[i] = DATA_W'($urandom);
            md  = 2'($urandom_range(0, 3));
            n   = $urandom_range(0, 3);
            cnt = n * DEPTH + 24;
            load(CNT_W'(n), md);
            collect(cnt, 2, -1, w, di, dc, se, to);
            build_exp(n, md, cnt, e);
            bad = 0;
            for (int i = 0; i < cnt; i++) if (w[i] !== e[i]) bad++;
            checks++;
            if (to != 0 || bad != 0) begin
                errors++;
                $display("FAIL random%0d_stream mode=%0d n=%0d got=%0d bad exp=0", it, md, n, bad);
            end
            checks++;
            if (se != 0 || di != n * DEPTH || dc != 1) begin
                errors++;
                $display("FAIL random%0d_ctrl got=stall%0d done%0d@%0d exp=stall0 done1@%0d",
                         it, se, dc, di, n * DEPTH);
            end
        end
    endtask

    task automatic test_mid_reset();
        wq_t w, e;
        int di, dc, se, to, bad;
        soft_restart();
        for (int i = 0; i < DEPTH; i++) pat[i] = DATA_W'($urandom);
        load(3, 2'd1);
        collect(2, 0, -1, w, di, dc, se, to);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state got=valid%b ready%b exp=valid0 ready1",
                     bus.out_valid, bus.in_ready);
        end
        RST = 1'b0;
        for (int i = 0; i < DEPTH; i++) pat[i] = DATA_W'($urandom);
        load(1, 2'd2);
        collect(DEPTH + 6, 2, -1, w, di, dc, se, to);
        build_exp(1, 2'd2, DEPTH + 6, e);
        bad = 0;
        for (int i = 0; i < DEPTH + 6; i++) if (w[i] !== e[i]) bad++;
        checks++;
        if (to != 0 || bad != 0 || w[0] !== pat[0]) begin
            errors++; $display("FAIL midrst_reload got=%0d bad first=%h exp=0 bad first=%h", bad, w[0], pat[0]);
        end
    endtask

    task automatic test_clear();
        wq_t w, e;
        int di, dc, se, to, bad;
        soft_restart();
        for (int i = 0; i < DEPTH; i++) pat[i] = DATA_W'($urandom);
        load(0, 2'd3);
        collect(3, 0, -1, w, di, dc, se, to);
        clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = DATA_W'($urandom);
        @(negedge CLK);
        clear = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL clear_state got=valid%b ready%b data%h exp=valid0 ready1 data00",
                     bus.out_valid, bus.in_ready, bus.out_data);
        end
        for (int i = 0; i < DEPTH; i++) pat[i] = DATA_W'($urandom);
        load(2, 2'd1);
        collect(2 * DEPTH + 5, 1, -1, w, di, dc, se, to);
        build_exp(2, 2'd1, 2 * DEPTH + 5, e);
        bad = 0;
        for (int i = 0; i < 2 * DEPTH + 5; i++) if (w[i] !== e[i]) bad++;
        checks++;
        if (to != 0 || bad != 0 || se != 0) begin
            errors++; $display("FAIL clear_reload got=%0d bad stall%0d exp=0 bad stall0", bad, se);
        end
    endtask

`ifdef PRBS_ERR_INJECT_EN
    task automatic test_err_inject();
        wq_t w, e;
        int di, dc, se, to;
        soft_restart();
        for (int i = 0; i < DEPTH; i++) pat[i] = DATA_W'($urandom);
        load(0, 2'd0);
        collect(4, 0, 1, w, di, dc, se, to);
        build_exp(0, 2'd0, 4, e);
        checks++;
        if (w[0] !== 8'h02 || w[1] !== 8'h0D) begin
            errors++; $display("FAIL inject_words got=%h,%h exp=02,0d", w[0], w[1]);
        end
        checks++;
        if (w[2] !== e[2] || w[3] !== e[3]) begin
            errors++; $display("FAIL inject_after got=%h,%h exp=%h,%h", w[2], w[3], e[2], e[3]);
        end
    endtask
`endif

    initial begin
        RST           = 1'b1;
        clear         = 1'b0;
        n_pattern     = '0;
        mode          = '0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
        err_inject    = 1'b0;
`endif
        test_reset();
        test_basic();
        test_backpressure();
        test_period();
        test_random();
        test_mid_reset();
        test_clear();
`ifdef PRBS_ERR_INJECT_EN
        test_err_inject();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
